// File: rtl/decode_queue.sv
// Decode stage: fetch queue, head decode, register scoreboard and a registered
// valid/ready output bundle toward execute.
module decode_queue #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREG   = 32,
    localparam int unsigned PW    = $clog2(QDEPTH),
    localparam int unsigned CW    = $clog2(QDEPTH + 1),
    localparam int unsigned CTLW  = 12
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_f_valid,
    input  logic [XLEN-1:0] i_f_pc,
    input  logic [31:0]     i_f_instr,
    output logic            o_f_ready,
    output logic [4:0]      o_ra1,
    output logic [4:0]      o_ra2,
    input  logic [XLEN-1:0] i_rd1,
    input  logic [XLEN-1:0] i_rd2,
    output logic            o_d_valid,
    input  logic            i_d_ready,
    output logic [XLEN-1:0] o_d_pc,
    output logic [XLEN-1:0] o_d_srca,
    output logic [XLEN-1:0] o_d_srcb,
    output logic [XLEN-1:0] o_d_imm,
    output logic [XLEN-1:0] o_d_memdata,
    output logic [XLEN-1:0] o_d_jaddr,
    output logic [CTLW-1:0] o_d_ctl,
    output logic [4:0]      o_d_rd,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,
    input  logic            i_flush,
    output logic [CW-1:0]   o_q_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    logic [XLEN-1:0] r_q_pc    [QDEPTH];
    logic [31:0]     r_q_instr [QDEPTH];
    logic [PW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count;
    logic [NREG-1:0] r_busy;

    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_pc, w_imm, w_srca, w_srcb, w_memdata, w_jaddr, w_jsum;
    logic [6:0]      w_op;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store;
    logic            w_opimm, w_opreg, w_use_rs1, w_use_rs2, w_wen;
    logic            w_hazard, w_push, w_issue;
    logic [CTLW-1:0] w_ctl;
    logic [NREG-1:0] w_busy_nxt;

    assign w_instr  = r_q_instr[r_head];
    assign w_pc     = r_q_pc[r_head];
    assign w_op     = w_instr[6:0];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];

    assign w_lui    = (w_op == OP_LUI);
    assign w_auipc  = (w_op == OP_AUIPC);
    assign w_jal    = (w_op == OP_JAL);
    assign w_jalr   = (w_op == OP_JALR);
    assign w_branch = (w_op == OP_BRANCH);
    assign w_load   = (w_op == OP_LOAD);
    assign w_store  = (w_op == OP_STORE);
    assign w_opimm  = (w_op == OP_IMM) || (w_op == OP_IMM32);
    assign w_opreg  = (w_op == OP_REG) || (w_op == OP_REG32);

    assign w_use_rs1 = !(w_lui || w_auipc || w_jal);
    assign w_use_rs2 = w_opreg || w_branch || w_store;
    assign w_wen     = w_lui || w_auipc || w_jal || w_jalr || w_load || w_opimm || w_opreg;

    // {funct7[5], funct3, alu_imm, wen, load, store, branch, jal, jalr, upper}
    assign w_ctl = {w_instr[30], w_instr[14:12], !(w_opreg || w_branch), w_wen, w_load,
                    w_store, w_branch, w_jal, w_jalr, (w_lui || w_auipc)};

    always_comb begin
        w_imm = '0;
        case (w_op)
            OP_LUI, OP_AUIPC:
                w_imm = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};
            OP_JAL:
                w_imm = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                         w_instr[30:21], 1'b0};
            OP_BRANCH:
                w_imm = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                         w_instr[11:8], 1'b0};
            OP_STORE:
                w_imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            default:
                w_imm = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
        endcase
    end

    assign w_srca    = (w_auipc || w_jal) ? w_pc : (w_lui ? '0 : i_rd1);
    assign w_srcb    = (w_opreg || w_branch) ? i_rd2 : w_imm;
    assign w_memdata = (w_store && w_instr[14:12] == 3'b011) ? '0 : i_rd2;
    assign w_jsum    = i_rd1 + w_imm;
    assign w_jaddr   = w_jalr ? {w_jsum[XLEN-1:1], 1'b0} : (w_pc + w_imm);

    // Only the registered busy state is consulted; a writeback unblocks next cycle.
    assign w_hazard = (w_use_rs1 && r_busy[w_rs1]) || (w_use_rs2 && r_busy[w_rs2]) ||
                      (w_wen && r_busy[w_rd]);

    assign o_f_ready = (r_count != CW'(QDEPTH)) && !i_flush;
    assign w_push    = i_f_valid && o_f_ready;
    assign w_issue   = (r_count != '0) && !w_hazard && !i_flush && (!o_d_valid || i_d_ready);
    assign o_ra1     = w_rs1;
    assign o_ra2     = w_rs2;
    assign o_q_count = r_count;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_valid && i_wb_rd != 5'd0) w_busy_nxt[i_wb_rd] = 1'b0;
        if (w_issue && w_wen && w_rd != 5'd0) w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= i_f_pc;
            r_q_instr[r_tail] <= i_f_instr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_busy      <= '0;
            o_d_valid   <= 1'b0;
            o_d_pc      <= '0;
            o_d_srca    <= '0;
            o_d_srcb    <= '0;
            o_d_imm     <= '0;
            o_d_memdata <= '0;
            o_d_jaddr   <= '0;
            o_d_ctl     <= '0;
            o_d_rd      <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_flush) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
                o_d_valid <= 1'b0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_issue) r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_issue);
                if (w_issue) begin
                    o_d_valid   <= 1'b1;
                    o_d_pc      <= w_pc;
                    o_d_srca    <= w_srca;
                    o_d_srcb    <= w_srcb;
                    o_d_imm     <= w_imm;
                    o_d_memdata <= w_memdata;
                    o_d_jaddr   <= w_jaddr;
                    o_d_ctl     <= w_ctl;
                    o_d_rd      <= w_rd;
                end else if (i_d_ready) begin
                    o_d_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Pipelined, back-pressured decode stage. It buffers fetched instructions in a parametrised queue, decodes the queue head through the existing `decoder`/`extend` units, and blocks RAW/WAW hazards with a register scoreboard. It registers the decoded bundle toward execute behind a valid/ready handshake. It sits between fetch and execute and replaces the single-cycle combinational decode path.

## Interface
Parameters:
- QDEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 64: datapath width (`word_t`).
- NREG, 32: architectural registers; x0 is never tracked.

Ports (one clock domain; reset is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch offers an instruction.
- f_pc  in  XLEN  pc of the offered instruction.
- f_instr  in  32  offered instruction word.
- f_ready  out  1  queue can accept; equals !full && !flush.
- ra1, ra2  out  5  regfile read addresses, taken from the queue head instr[19:15] and instr[24:20].
- rd1, rd2  in  XLEN  regfile read data (combinational read).
- d_valid  out  1  decoded bundle valid.
- d_ready  in  1  execute accepts the bundle.
- d_pc, d_srca, d_srcb, d_imm, d_memdata, d_jaddr  out  XLEN  registered operands and jump target.
- d_ctl  out  decode_control_t  registered control.
- d_rd  out  5  destination register.
- wb_valid  in  1  a writeback retires this cycle.
- wb_rd  in  5  writeback destination.
- flush  in  1  redirect; kills the queue and the output register.
- q_count  out  $clog2(QDEPTH+1)  current occupancy (debug/perf).

## Operation
- Queue: circular buffer with head/tail pointers of $clog2(QDEPTH) bits that wrap modulo QDEPTH, plus an occupancy counter.
  - Push when f_valid && f_ready.
  - Pop on issue.
  - Push and pop in the same cycle leave the count unchanged. This is legal when full, but f_ready is still 0 when full, so no push occurs that cycle.
- Head decode: the decoder and extend units read the head instruction. Operand and jump-target selection is unchanged from the existing decode path:
  - JALR target = (rd1+imm)&~1; otherwise target = pc+imm.
  - memdata = rd2, except SD where memdata = 0.
- Source usage comes from the decoder: rs1 is used unless the op is LUI, AUIPC or JAL; rs2 is used for R-type, branch and store ops.
- Scoreboard: a busy vector of NREG bits; bit 0 is hard-wired to 0.
  - hazard = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) || (wen && busy[rd]).
  - The check uses only the registered busy value; there is no writeback bypass.
- Issue condition: count≠0 && !hazard && !flush && (!d_valid || d_ready).
  - On issue: load all d_* registers, set d_valid=1, pop the head, and set busy[rd] if wen && rd≠0.
- Hold: if d_valid && !d_ready, all d_* outputs hold stable.
- Drain: if d_valid && d_ready and no issue occurs that cycle, d_valid goes to 0.
- Writeback: wb_valid && wb_rd≠0 clears busy[wb_rd]. The same register is never set and cleared in one cycle, because the WAW check stalls any issue to a busy rd.
- Flush (takes priority over everything except reset):
  - Pointers and count go to 0, and d_valid goes to 0.
  - The push and the issue in that cycle are suppressed.
  - Busy bits are NOT cleared, because older issued instructions still write back. A wb clear in the flush cycle is still applied.

## Timing
- Reset values: count=0, pointers=0, d_valid=0, all d_* data=0, busy=0, f_ready=1, q_count=0.
- Latency, hazard-free, d_ready=1: an instruction pushed in cycle N is the head in N+1, issues at the end of N+1, and shows d_valid=1 in N+2.
- Throughput: 1 instruction/cycle with no hazards and d_ready held high.
- RAW stall: a consumer waits until the cycle after wb_valid for its source; it issues in the cycle following the clear.
- d_valid and all d_* outputs come straight from flops. f_ready, ra1 and ra2 are combinational from state and flush.
- Reset asserted mid-operation clears all state asynchronously. The queue contents array need not be reset.

## Test plan
- Streaming: push 8 independent ADDI to distinct rd with d_ready=1 -> d_valid from cycle 2, one bundle/cycle, pcs in order, busy bits set for x1..x8.
- Full/back-pressure: QDEPTH=4, d_ready=0, push 6 -> f_ready=0 once q_count=4 with 1 bundle held in the output register; the held bundle stays stable; releasing d_ready drains in order with none lost or duplicated.
- RAW: issue `addi x5,x0,1`, then `add x6,x5,x5` -> the second stalls with busy[5]=1; pulse wb_valid/wb_rd=5 in cycle K -> the second shows d_valid in K+2.
- x0/WAW: `addi x0,...` then a consumer of x0 -> no stall. Two writes to x7 -> the second waits for wb_rd=7.
- Flush: q_count=3 with d_valid=1, assert flush together with f_valid and wb_rd=5 -> next cycle q_count=0, d_valid=0, the offered instruction is dropped, busy[5] is cleared, and other busy bits are retained.
- Wrap: 3×QDEPTH pushes and pops with random d_ready -> output order equals input order across pointer wrap.
